// File: rtl/mode_nav_controller.sv
// mode_nav_controller
//   Debounces five push buttons and runs the MENU / PREVIEW / ACTIVE
//   navigation FSM for the seven-segment mode selector.
// Ports:
//   IN_CLK         single clock, rising edge
//   IN_RST_N       asynchronous active-low reset
//   IN_BTN[4:0]    raw buttons, active high (0 confirm, 1 back, 2 prev, 3 next, 4 aux)
//   OUT_DATA[2:0]  display selector index (0 = select screen, 1..NUM_MODES = mode)
//   OUT_ACTIVE     high while a mode runs
//   OUT_MODE_EN    one-hot enable, bit k = mode k+1 active
//   OUT_KEY_PULSE  one-cycle key pulses forwarded to the active mode
module mode_nav_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1_000_000_000,
  parameter int NUM_MODES       = 5
) (
  input  logic       IN_CLK,
  input  logic       IN_RST_N,
  input  logic [4:0] IN_BTN,
  output logic [2:0] OUT_DATA,
  output logic       OUT_ACTIVE,
  output logic [6:0] OUT_MODE_EN,
  output logic [4:0] OUT_KEY_PULSE
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_MENU, S_PREVIEW, S_ACTIVE} state_t;

  logic [4:0] r_sync1, r_sync2, r_level_d, r_pulse;
  logic [4:0] w_level;

  // Synchronizer plus one-stage edge detector on the debounced levels.
  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level_d <= '0;
      r_pulse   <= '0;
    end else begin
      r_sync1   <= IN_BTN;
      r_sync2   <= r_sync1;
      r_level_d <= w_level;
      r_pulse   <= w_level & ~r_level_d;
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_db
    logic [DW-1:0] r_cnt;
    logic          r_lvl;
    // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
      if (!IN_RST_N) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[gi] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt <= '0;
        r_lvl <= r_sync2[gi];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_level[gi] = r_lvl;
  end

  state_t        r_state;
  logic [2:0]    r_cursor;
  logic [IW-1:0] r_idle;

  // Priority back > confirm > next > prev; lower ones are masked.
  logic w_back, w_conf, w_next, w_prev, w_timeout;
  logic [2:0] w_cur_inc, w_cur_dec;
  logic [6:0] w_en_cur;
  assign w_back    = r_pulse[1];
  assign w_conf    = r_pulse[0] & ~r_pulse[1];
  assign w_next    = r_pulse[3] & ~r_pulse[1] & ~r_pulse[0];
  assign w_prev    = r_pulse[2] & ~r_pulse[1] & ~r_pulse[0] & ~r_pulse[3];
  assign w_timeout = (r_idle == IW'(TIMEOUT_CYCLES));
  assign w_cur_inc = (r_cursor == 3'(NUM_MODES)) ? 3'd1 : r_cursor + 3'd1;
  assign w_cur_dec = (r_cursor == 3'd1) ? 3'(NUM_MODES) : r_cursor - 3'd1;
  assign w_en_cur  = 7'b1 << (r_cursor - 3'd1);

  // Idle counter only runs in PREVIEW; any press pulse restarts it. Held at 0
  // elsewhere so entry to PREVIEW always starts from 0.
  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N)
      r_idle <= '0;
    else if (r_state != S_PREVIEW || |r_pulse)
      r_idle <= '0;
    else if (!w_timeout)
      r_idle <= r_idle + 1'b1;
  end

  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      r_state       <= S_MENU;
      r_cursor      <= 3'd1;
      OUT_DATA      <= '0;
      OUT_ACTIVE    <= 1'b0;
      OUT_MODE_EN   <= '0;
      OUT_KEY_PULSE <= '0;
    end else begin
      OUT_KEY_PULSE <= '0;
      case (r_state)
        S_MENU: begin
          if (w_conf | w_next | w_prev) begin
            r_state  <= S_PREVIEW;
            OUT_DATA <= r_cursor;
          end
        end
        S_PREVIEW: begin
          if (w_back) begin
            r_state  <= S_MENU;
            OUT_DATA <= '0;
          end else if (w_conf) begin
            r_state     <= S_ACTIVE;
            OUT_ACTIVE  <= 1'b1;
            OUT_MODE_EN <= w_en_cur;
          end else if (w_next) begin
            r_cursor <= w_cur_inc;
            OUT_DATA <= w_cur_inc;
          end else if (w_prev) begin
            r_cursor <= w_cur_dec;
            OUT_DATA <= w_cur_dec;
          end else if (!r_pulse[4] && w_timeout) begin
            // aux still counts as activity and beats the timeout
            r_state  <= S_MENU;
            OUT_DATA <= '0;
          end
        end
        S_ACTIVE: begin
          if (w_back) begin
            r_state     <= S_PREVIEW;
            OUT_ACTIVE  <= 1'b0;
            OUT_MODE_EN <= '0;
          end else begin
            OUT_KEY_PULSE <= r_pulse & 5'b11101;
          end
        end
        default: begin
          r_state     <= S_MENU;
          OUT_DATA    <= '0;
          OUT_ACTIVE  <= 1'b0;
          OUT_MODE_EN <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mode_nav_controller.sv
// Scoreboard bench for mode_nav_controller (DEBOUNCE=4, TIMEOUT=20, MODES=5).
// Every expected output change is queued with the cycle it must appear in;
// the monitor pops one entry per observed output change.
module tb_mode_nav_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] btn = '0;
  logic [2:0] data;
  logic       act;
  logic [6:0] en;
  logic [4:0] key;

  mode_nav_controller #(
    .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20), .NUM_MODES(5)
  ) dut (
    .IN_CLK(clk), .IN_RST_N(rst_n), .IN_BTN(btn),
    .OUT_DATA(data), .OUT_ACTIVE(act), .OUT_MODE_EN(en), .OUT_KEY_PULSE(key)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [15:0] val; } exp_t;
  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [15:0] prev = '0;
  int          t0;

  always @(posedge clk) cyc++;

  function automatic logic [15:0] pk(logic [2:0] d, logic a, logic [6:0] e, logic [4:0] k);
    return {d, a, e, k};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic ex(int c, logic [2:0] d, logic a, logic [6:0] e, logic [4:0] k);
    exp_t x;
    x.cyc = c;
    x.val = pk(d, a, e, k);
    q.push_back(x);
  endtask

  task automatic press(logic [4:0] b, int hold, int settle);
    btn = b;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic wait_q(string nm, int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, q.size(), 0);
    q.delete();
  endtask

  // Monitor: each output change (sampled at negedge) pops one expectation.
  always @(negedge clk) begin : mon
    logic [15:0] cur;
    exp_t e;
    cur = pk(data, act, en, key);
    if (mon_en && cur !== prev) begin
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_change: got 0x%0h, want 0x%0h (cycle %0d)", cur, prev, cyc);
      end else begin
        e = q.pop_front();
        chk("out_value", cur, e.val);
        chk("out_cycle", cyc, e.cyc);
      end
    end
    prev = cur;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data", data, 0);
    chk("rst_active", act, 0);
    chk("rst_mode_en", en, 0);
    chk("rst_key", key, 0);
    @(negedge clk); @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // next held 10 cycles: MENU -> PREVIEW at edge 7, cursor 1
    t0 = cyc; ex(t0 + 8, 1, 0, 0, 0); press(5'b01000, 10, 6);
    // prev wraps 1 -> 5, next wraps 5 -> 1, then walk down to 3
    t0 = cyc; ex(t0 + 8, 5, 0, 0, 0); press(5'b00100, 6, 6);
    t0 = cyc; ex(t0 + 8, 1, 0, 0, 0); press(5'b01000, 6, 6);
    t0 = cyc; ex(t0 + 8, 5, 0, 0, 0); press(5'b00100, 6, 6);
    t0 = cyc; ex(t0 + 8, 4, 0, 0, 0); press(5'b00100, 6, 6);
    t0 = cyc; ex(t0 + 8, 3, 0, 0, 0); press(5'b00100, 6, 6);
    wait_q("preview_nav_drained", 40);

    // confirm at cursor 3 -> ACTIVE
    t0 = cyc; ex(t0 + 8, 3, 1, 7'b0000100, 0); press(5'b00001, 6, 6);
    // keys forwarded for one cycle, cursor frozen
    t0 = cyc; ex(t0 + 8, 3, 1, 7'b0000100, 5'b01000); ex(t0 + 9, 3, 1, 7'b0000100, 0);
    press(5'b01000, 6, 6);
    t0 = cyc; ex(t0 + 8, 3, 1, 7'b0000100, 5'b10000); ex(t0 + 9, 3, 1, 7'b0000100, 0);
    press(5'b10000, 6, 6);
    t0 = cyc; ex(t0 + 8, 3, 1, 7'b0000100, 5'b00100); ex(t0 + 9, 3, 1, 7'b0000100, 0);
    press(5'b00100, 6, 6);
    // back -> PREVIEW, no key pulse
    t0 = cyc; ex(t0 + 8, 3, 0, 0, 0); press(5'b00010, 6, 6);
    wait_q("active_drained", 40);

    // 3-cycle glitch on confirm: nothing expected
    btn = 5'b00001; repeat (3) @(negedge clk);
    btn = '0;       repeat (3) @(negedge clk);
    // back + next together -> MENU (back wins)
    t0 = cyc; ex(t0 + 8, 0, 0, 0, 0); press(5'b01010, 6, 6);
    // confirm from MENU: cursor still 3; then idle timeout 21 edges after entry
    t0 = cyc; ex(t0 + 8, 3, 0, 0, 0); ex(t0 + 29, 0, 0, 0, 0); press(5'b00001, 6, 6);
    wait_q("timeout_drained", 60);

    // aux pulse landing in the timeout cycle restarts the idle counter
    t0 = cyc; ex(t0 + 8, 3, 0, 0, 0); ex(t0 + 50, 0, 0, 0, 0);
    press(5'b00100, 6, 6);
    repeat (9) @(negedge clk);
    press(5'b10000, 6, 6);
    wait_q("timeout_restart_drained", 60);

    // into ACTIVE, then reset mid-ACTIVE
    t0 = cyc; ex(t0 + 8, 3, 0, 0, 0); press(5'b00001, 6, 6);
    t0 = cyc; ex(t0 + 8, 3, 1, 7'b0000100, 0); press(5'b00001, 6, 6);
    wait_q("reentry_drained", 40);
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0; btn = 5'b00001;
    #1;
    chk("async_rst_data", data, 0);
    chk("async_rst_active", act, 0);
    chk("async_rst_mode_en", en, 0);
    chk("async_rst_key", key, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc; mon_en = 1'b1;
    // confirm held through release: one press -> PREVIEW with reset cursor 1
    ex(t0 + 8, 1, 0, 0, 0); ex(t0 + 29, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    btn = '0;
    wait_q("held_through_reset_drained", 60);

    repeat (20) @(negedge clk);
    chk("queue_empty_end", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/mode_nav_controller.md
# mode_nav_controller

Button-driven navigation controller for the two 4-digit seven-segment displays. It debounces the five push buttons and runs a menu state machine: select screen, mode preview, mode active. It drives the 3-bit `data` select input of the mode-selector display block, and gives one-hot enables to the mode sub-blocks (display, counter, timer, …). While a mode is active, it forwards clean single-cycle key pulses to that mode.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed before a button level is accepted (10 ms at 100 MHz); legal range ≥2.
- `TIMEOUT_CYCLES`, default 1_000_000_000: idle cycles in PREVIEW before the controller falls back to MENU; legal range ≥2.
- `NUM_MODES`, default 5: number of selectable modes; legal range 2..7.
- `IN_CLK` input 1: the single clock; all logic is on the rising edge.
- `IN_RST_N` input 1: asynchronous, active-low reset.
- `IN_BTN` input 5: raw buttons, active high. Bit 0 = confirm, 1 = back, 2 = prev, 3 = next, 4 = aux.
- `OUT_DATA` output 3: mode index sent to the display selector. 0 = select screen; 1..NUM_MODES = mode.
- `OUT_ACTIVE` output 1: high while a mode is running.
- `OUT_MODE_EN` output 7: one-hot mode enable. Bit k is high when mode k+1 is active. Bits ≥NUM_MODES are always 0.
- `OUT_KEY_PULSE` output 5: debounced one-cycle key pulses forwarded to the active mode.

## Operation
- Each button passes through a 2-FF synchronizer, then a per-button debouncer.
  - The debounced level changes once the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any cycle where the two agree clears that button's counter.
  - A 0→1 change of the debounced level produces a one-cycle press pulse.
  - Release makes no pulse. A button held down produces exactly one pulse.
- FSM state MENU:
  - Outputs: `OUT_DATA`=0, `OUT_ACTIVE`=0.
  - Confirm, next or prev → PREVIEW. The cursor keeps its value.
- FSM state PREVIEW:
  - Output: `OUT_DATA`=cursor.
  - Next: cursor+1, wrapping NUM_MODES→1.
  - Prev: cursor−1, wrapping 1→NUM_MODES.
  - Confirm → ACTIVE.
  - Back → MENU.
  - Idle timeout → MENU.
- FSM state ACTIVE:
  - Outputs: `OUT_DATA`=cursor, `OUT_ACTIVE`=1, `OUT_MODE_EN` bit cursor−1 = 1.
  - Back → PREVIEW.
  - Back is consumed here. The pulses of buttons 0, 2, 3 and 4 are copied to `OUT_KEY_PULSE` in the same cycle the FSM sees them.
  - Cursor changes are ignored.
- Aux (bit 4) has no navigation effect. It is forwarded only in ACTIVE.
- Simultaneous pulses in one cycle: only the highest priority acts. Priority is back > confirm > next > prev; the others are dropped.
- The idle counter:
  - clears on entry to PREVIEW and on every press pulse;
  - counts only in PREVIEW;
  - when it reaches `TIMEOUT_CYCLES` it forces MENU.
  - A pulse arriving in the timeout cycle takes priority over the timeout.
- `OUT_KEY_PULSE` is 0 in MENU and PREVIEW. The pulse that causes an ACTIVE exit or entry is not forwarded.

## Timing
- Reset values:
  - state MENU, cursor 1;
  - `OUT_DATA`=0, `OUT_ACTIVE`=0, `OUT_MODE_EN`=0, `OUT_KEY_PULSE`=0;
  - synchronizers, debounced levels and all counters at 0.
- A button held through reset release counts as a new press. It pulses once after debouncing.
- All outputs are registered.
- Latency: after a clean button rise sampled at edge 0, the FSM outputs (`OUT_DATA`, `OUT_ACTIVE`, `OUT_MODE_EN`) update at edge `DEBOUNCE_CYCLES`+3.
- `OUT_KEY_PULSE` is high for exactly one cycle, starting at edge `DEBOUNCE_CYCLES`+3.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- Timeout: MENU is entered exactly `TIMEOUT_CYCLES`+1 edges after the last PREVIEW entry or pulse.
- Asserting reset in any state returns to MENU immediately. `OUT_MODE_EN` drops with no clock.
- Counter widths:
  - debouncer counters: ceil(log2(DEBOUNCE_CYCLES+1));
  - idle counter: ceil(log2(TIMEOUT_CYCLES+1)); it saturates and never wraps.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=20, `NUM_MODES`=5.
- Reset, then press next for 10 cycles → `OUT_DATA` goes 0→1 at edge 7; one transition only.
- In PREVIEW at cursor 5, press next → `OUT_DATA`=1. Then press prev → `OUT_DATA`=5.
- Cursor 3, press confirm → `OUT_ACTIVE`=1, `OUT_MODE_EN`=0000100. Press next → `OUT_KEY_PULSE`=01000 for one cycle and `OUT_DATA` stays 3. Press back → `OUT_ACTIVE`=0, `OUT_MODE_EN`=0, `OUT_DATA`=3, no key pulse.
- A 3-cycle high glitch on confirm → no state change. Back and next pressed on the same cycle in PREVIEW → MENU, cursor unchanged.
- Enter PREVIEW with no further input → `OUT_DATA`=0 exactly 21 edges later. A press at edge 20 instead resets the counter and the state stays PREVIEW.
- Assert `IN_RST_N`=0 mid-ACTIVE → all outputs 0 immediately. Keep confirm held through release → PREVIEW, not ACTIVE, 7 edges after release.
